// File: rtl/srt_div_pkg.sv
// Shared types and constants for the radix-2 SRT divider.
// Holds the FSM state encoding, the redundant digit encoding and the default width.
package srt_div_pkg;

    // Default operand/result width.
    localparam int SRT_W = 8;

    // Digit-select threshold: |2*P2| must reach 2^W before a nonzero digit is chosen.
    localparam int SRT_THRESH = 1 << SRT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_CORR = 2'd2
    } state_t;

    // Redundant quotient digit, packed as {pos, neg}.
    typedef enum logic [1:0] {
        DIG_ZERO = 2'b00,
        DIG_NEG  = 2'b01,
        DIG_POS  = 2'b10
    } digit_t;

endpackage

// File: rtl/srt_qsel.sv
// SRT quotient-digit selection from the top four bits of T = 2*P2.
// Ports: TOP = T[W+2:W-1]; POS/NEG = one-hot digit {+1,-1}, both low for 0.
module srt_qsel
    import srt_div_pkg::*;
(
    input  logic [3:0] TOP,
    output logic       POS,
    output logic       NEG
);

    digit_t dig;

    // TOP[3] is the sign of T and TOP[2:1] its weight-2^W bits.
    // Positive T with any 2^W bit set means T >= 2^W.
    // Negative T with TOP[2:1] != 2'b11 means T < -2^W.
    always_comb begin
        dig = DIG_ZERO;
        unique case (TOP)
            4'b0010, 4'b0011,
            4'b0100, 4'b0101,
            4'b0110, 4'b0111: dig = DIG_POS;
            4'b1000, 4'b1001,
            4'b1010, 4'b1011,
            4'b1100, 4'b1101: dig = DIG_NEG;
            default:          dig = DIG_ZERO;
        endcase
    end

    assign {POS, NEG} = dig;

endmodule

// File: rtl/srt_div_core.sv
// Radix-2 SRT iterative unsigned divider: one digit per clock, then one correction cycle.
// Ports: CLK, RST (sync, active-high); START/DVD/DSR_N/LZ request (DSR_N = divisor << LZ);
//        BUSY, DONE pulse, DVZ, Q, R (Q/R/DVZ held until the next DONE).
module srt_div_core
    import srt_div_pkg::*;
#(
    parameter int W  = SRT_W,
    parameter int LW = $clog2(W)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [W-1:0]  DVD,
    input  logic [W-1:0]  DSR_N,
    input  logic [LW-1:0] LZ,
    output logic          BUSY,
    output logic          DONE,
    output logic          DVZ,
    output logic [W-1:0]  Q,
    output logic [W-1:0]  R
);

    // Partial remainder width: |P2| <= D2 < 2^(W+1), and T = 2*P2 still fits.
    localparam int PW = W + 3;

    state_t        state, state_n;
    logic [PW-1:0] p2, p2_n;
    logic [PW-1:0] d2, d2_n;
    logic [PW-1:0] t;
    logic [PW-1:0] pc;
    logic [W-1:0]  qp, qp_n;
    logic [W-1:0]  qn, qn_n;
    logic [W-1:0]  qc;
    logic [W-1:0]  q_r, q_n;
    logic [W-1:0]  r_r, r_n;
    logic [LW-1:0] cnt, cnt_n;
    logic [LW-1:0] lz, lz_n;
    logic          done_r, done_n;
    logic          dvz_r, dvz_n;
    logic          pos, neg;

    // T = 2*P2; the top bit of P2 is never needed here because no overflow occurs.
    assign t = {p2[PW-2:0], 1'b0};

    srt_qsel u_qsel (
        .TOP (t[PW-1:PW-4]),
        .POS (pos),
        .NEG (neg)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            p2     <= '0;
            d2     <= '0;
            qp     <= '0;
            qn     <= '0;
            cnt    <= '0;
            lz     <= '0;
            q_r    <= '0;
            r_r    <= '0;
            done_r <= 1'b0;
            dvz_r  <= 1'b0;
        end else begin
            state  <= state_n;
            p2     <= p2_n;
            d2     <= d2_n;
            qp     <= qp_n;
            qn     <= qn_n;
            cnt    <= cnt_n;
            lz     <= lz_n;
            q_r    <= q_n;
            r_r    <= r_n;
            done_r <= done_n;
            dvz_r  <= dvz_n;
        end
    end

    always_comb begin
        state_n = state;
        p2_n    = p2;
        d2_n    = d2;
        qp_n    = qp;
        qn_n    = qn;
        cnt_n   = cnt;
        lz_n    = lz;
        q_n     = q_r;
        r_n     = r_r;
        done_n  = 1'b0;
        dvz_n   = dvz_r;
        qc      = qp - qn;
        pc      = p2;

        unique case (state)
            S_IDLE: begin
                if (START) begin
                    if (DSR_N == '0) begin
                        // Divide by zero finishes without leaving IDLE.
                        done_n = 1'b1;
                        dvz_n  = 1'b1;
                        q_n    = '1;
                        r_n    = DVD;
                    end else begin
                        p2_n    = {3'b000, DVD};
                        d2_n    = {2'b00, DSR_N, 1'b0};
                        qp_n    = '0;
                        qn_n    = '0;
                        cnt_n   = '0;
                        lz_n    = LZ;
                        state_n = S_ITER;
                    end
                end
            end

            S_ITER: begin
                if (pos) begin
                    p2_n = t - d2;
                end else if (neg) begin
                    p2_n = t + d2;
                end else begin
                    p2_n = t;
                end
                qp_n  = {qp[W-2:0], pos};
                qn_n  = {qn[W-2:0], neg};
                cnt_n = cnt + LW'(1);
                // LZ+1 digits in total.
                if (cnt == lz) begin
                    state_n = S_CORR;
                end
            end

            S_CORR: begin
                // A negative final remainder means the last digits overshot by one.
                if (p2[PW-1]) begin
                    qc = qp - qn - W'(1);
                    pc = p2 + d2;
                end
                q_n     = qc;
                // Undo the divisor normalisation and the extra factor of two in D2.
                r_n     = W'((pc >> 1) >> lz);
                done_n  = 1'b1;
                dvz_n   = 1'b0;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign BUSY = (state != S_IDLE);
    assign DONE = done_r;
    assign DVZ  = dvz_r;
    assign Q    = q_r;
    assign R    = r_r;

endmodule
